// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermometer display decoder.
package thermo_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned TEMP_W = 5;

  localparam logic [TEMP_W-1:0] T_MIN   = 5'd19;
  localparam logic [TEMP_W-1:0] T_MAX   = 5'd26;
  localparam logic [TEMP_W-1:0] T_UNDER = 5'd18;
  localparam logic [TEMP_W-1:0] T_OVER  = 5'd27;

  typedef enum logic [1:0] {
    RangeNormal  = 2'b00,
    RangeUnder   = 2'b01,
    RangeOver    = 2'b10,
    RangeInvalid = 2'b11
  } range_e;

  typedef enum logic {
    StTrack,
    StPend
  } state_e;

endpackage

// File: rtl/thermo_code_check.sv
// Combinational decode of {alert, thermometer word} into temperature and range class.
module thermo_code_check
  import thermo_pkg::*;
(
  input  logic              alert_i,
  input  logic [CODE_W-1:0] coded_i,
  output logic [TEMP_W-1:0] temp_o,
  output range_e            range_o
);

  logic [3:0] ones;
  logic       legal;

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      ones = ones + 4'(coded_i[i]);
    end
    // Ones contiguous from bit 0 means the word is 2^n - 1.
    legal = (coded_i != '0) && ((coded_i & (coded_i + CODE_W'(1))) == '0);

    if (!alert_i && legal) begin
      range_o = RangeNormal;
      temp_o  = T_UNDER + TEMP_W'(ones);
    end else if (alert_i && coded_i == CODE_W'(1)) begin
      range_o = RangeUnder;
      temp_o  = T_UNDER;
    end else if (alert_i && coded_i == '1) begin
      range_o = RangeOver;
      temp_o  = T_OVER;
    end else begin
      range_o = RangeInvalid;
      temp_o  = '0;
    end
  end

endmodule

// File: rtl/thermo_display_decoder.sv
// Synchronizes, debounces and decodes the thermometer display word, reporting each new
// reading over valid/ready and tracking alert events and code errors.
module thermo_display_decoder
  import thermo_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CODE_W-1:0] coded_i,
  input  logic              alert_i,
  input  logic              ready_i,
  input  logic              clr_i,
  output logic              valid_o,
  output logic [TEMP_W-1:0] temp_o,
  output logic [1:0]        range_o,
  output logic              code_err_o,
  output logic [CNT_W-1:0]  alert_cnt_o
);

  localparam int unsigned SampW      = CODE_W + 1;
  localparam logic [3:0]  StableMax  = 4'(STABLE_CYCLES);
  localparam logic [3:0]  StableQual = 4'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SampW-1:0] sync_q, sync_d;
  logic [SampW-1:0]  samp, prev_q, prev_d, last_q, last_d;
  logic [3:0]        stab_q, stab_d;
  logic              last_vld_q, last_vld_d;
  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [TEMP_W-1:0] temp_q, temp_d, dec_temp;
  range_e            range_q, range_d, dec_range;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              qualified, report, alert_ev, inv_ev;

  assign samp = sync_q[SYNC_STAGES-1];

  thermo_code_check u_code_check (
    .alert_i (samp[CODE_W]),
    .coded_i (samp[CODE_W-1:0]),
    .temp_o  (dec_temp),
    .range_o (dec_range)
  );

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {alert_i, coded_i}};
    prev_d = samp;

    if (samp != prev_q) begin
      stab_d = 4'd0;
    end else if (stab_q < StableMax) begin
      stab_d = stab_q + 4'd1;
    end else begin
      stab_d = stab_q;
    end
    qualified = (samp == prev_q) && (stab_q >= StableQual);

    report     = 1'b0;
    state_d    = state_q;
    valid_d    = valid_q;
    temp_d     = temp_q;
    range_d    = range_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;

    case (state_q)
      StTrack: begin
        if (qualified && (!last_vld_q || samp != last_q)) begin
          report     = 1'b1;
          state_d    = StPend;
          valid_d    = 1'b1;
          temp_d     = dec_temp;
          range_d    = dec_range;
          last_d     = samp;
          last_vld_d = 1'b1;
        end
      end
      StPend: begin
        if (ready_i) begin
          state_d = StTrack;
          valid_d = 1'b0;
        end
      end
      default: state_d = StTrack;
    endcase

    alert_ev = report && (dec_range == RangeUnder || dec_range == RangeOver);
    inv_ev   = report && (dec_range == RangeInvalid);

    // A clear coinciding with an event keeps that event.
    if (clr_i) begin
      cnt_d = alert_ev ? CNT_W'(1) : '0;
    end else if (alert_ev && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    err_d = inv_ev | (err_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q     <= '0;
      prev_q     <= '0;
      stab_q     <= 4'd0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      state_q    <= StTrack;
      valid_q    <= 1'b0;
      temp_q     <= '0;
      range_q    <= RangeNormal;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      stab_q     <= stab_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      temp_q     <= temp_d;
      range_q    <= range_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign valid_o     = valid_q;
  assign temp_o      = temp_q;
  assign range_o     = range_q;
  assign code_err_o  = err_q;
  assign alert_cnt_o = cnt_q;

endmodule

// File: tb/tb_thermo_display_decoder.sv
// Directed bench for thermo_display_decoder (default and 2-bit alert counter instances).
module tb_thermo_display_decoder;
  import thermo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ready, clr, alert;
  logic [7:0] coded;

  logic       valid, err;
  logic [4:0] temp;
  logic [1:0] rng;
  logic [7:0] cnt;

  logic       valid2, err2;
  logic [4:0] temp2;
  logic [1:0] rng2;
  logic [1:0] cnt2;

  logic       ref_alert;
  logic [7:0] ref_coded;
  logic [4:0] ref_temp;
  range_e     ref_range;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thermo_display_decoder dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .coded_i     (coded),
    .alert_i     (alert),
    .ready_i     (ready),
    .clr_i       (clr),
    .valid_o     (valid),
    .temp_o      (temp),
    .range_o     (rng),
    .code_err_o  (err),
    .alert_cnt_o (cnt)
  );

  thermo_display_decoder #(.CNT_W(2)) dut2 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .coded_i     (coded),
    .alert_i     (alert),
    .ready_i     (ready),
    .clr_i       (clr),
    .valid_o     (valid2),
    .temp_o      (temp2),
    .range_o     (rng2),
    .code_err_o  (err2),
    .alert_cnt_o (cnt2)
  );

  thermo_code_check u_ref (
    .alert_i (ref_alert),
    .coded_i (ref_coded),
    .temp_o  (ref_temp),
    .range_o (ref_range)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with the word applied; the next posedge after return is edge 0.
  task automatic do_reset(input logic [7:0] c, input logic a, input logic rdy);
    rst_n = 1'b0; coded = c; alert = a; ready = rdy; clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_code_check();
    logic [15:0] vec [8];
    logic [6:0]  exp [8];
    vec = '{{8'h00, 8'h01}, {8'h00, 8'hFF}, {8'h00, 8'h00}, {8'h00, 8'h05},
            {8'h01, 8'h01}, {8'h01, 8'hFF}, {8'h01, 8'h03}, {8'h00, 8'h80}};
    exp = '{{5'd19, 2'b00}, {5'd26, 2'b00}, {5'd0, 2'b11}, {5'd0, 2'b11},
            {5'd18, 2'b01}, {5'd27, 2'b10}, {5'd0, 2'b11}, {5'd0, 2'b11}};
    for (int i = 0; i < 8; i++) begin
      ref_alert = vec[i][8];
      ref_coded = vec[i][7:0];
      #1;
      n_vec++;
      if ({ref_temp, ref_range} !== exp[i]) begin
        n_bad++;
        $display("FAIL code_check[%0d]: got temp=%0d range=%0d want temp=%0d range=%0d",
                 i, ref_temp, ref_range, exp[i][6:2], exp[i][1:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coded = 8'hFF; alert = 1'b1; ready = 1'b0; clr = 1'b0;
    #3;
    n_vec++;
    if ({valid, temp, rng, err, cnt, valid2, cnt2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%0b t=%0d r=%0d e=%0b c=%0d c2=%0d want all 0",
               valid, temp, rng, err, cnt, cnt2);
    end
    tick();
    tick();
    n_vec++;
    if ({valid, temp, rng, err, cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_held: got v=%0b t=%0d r=%0d want all 0", valid, temp, rng);
    end
  endtask

  task automatic test_normal_pulse();
    int highs;
    do_reset(8'h07, 1'b0, 1'b1);
    highs = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (valid) highs++;
    end
    n_vec++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL normal_early: got %0d early valid cycles want 0", highs);
    end
    tick();
    n_vec++;
    if ({valid, temp, rng} !== {1'b1, 5'd21, 2'b00}) begin
      n_bad++;
      $display("FAIL normal_edge6: got v=%0b t=%0d r=%0d want v=1 t=21 r=0", valid, temp, rng);
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid) highs++;
    end
    n_vec++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL normal_single_pulse: got %0d extra valid cycles want 0", highs);
    end
    n_vec++;
    if ({err, cnt} !== '0) begin
      n_bad++;
      $display("FAIL normal_flags: got err=%0b cnt=%0d want 0 0", err, cnt);
    end
  endtask

  task automatic test_over_hold();
    int highs;
    do_reset(8'hFF, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) tick();
    tick();
    n_vec++;
    if ({valid, temp, rng, cnt} !== {1'b1, 5'd27, 2'b10, 8'd1}) begin
      n_bad++;
      $display("FAIL over_entry: got v=%0b t=%0d r=%0d c=%0d want v=1 t=27 r=2 c=1",
               valid, temp, rng, cnt);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_vec++;
      if ({valid, temp, rng} !== {1'b1, 5'd27, 2'b10}) begin
        n_bad++;
        $display("FAIL over_hold[%0d]: got v=%0b t=%0d r=%0d want v=1 t=27 r=2",
                 i, valid, temp, rng);
      end
    end
    ready = 1'b1;
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL over_handshake: got valid=%0b want 0", valid);
    end
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) highs++;
    end
    n_vec++;
    if (highs != 0 || cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL over_no_repeat: got highs=%0d cnt=%0d want 0 1", highs, cnt);
    end
  endtask

  task automatic test_invalid_err();
    do_reset(8'h05, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) tick();
    tick();
    n_vec++;
    if ({valid, temp, rng, err} !== {1'b1, 5'd0, 2'b11, 1'b1}) begin
      n_bad++;
      $display("FAIL invalid_entry: got v=%0b t=%0d r=%0d e=%0b want v=1 t=0 r=3 e=1",
               valid, temp, rng, err);
    end
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_sticky: got err=%0b want 1", err);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_clr: got err=%0b want 0", err);
    end
    coded = 8'h09;
    for (int i = 1; i <= 6; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if ({valid, rng, err} !== {1'b1, 2'b11, 1'b1}) begin
      n_bad++;
      $display("FAIL invalid_clr_collide: got v=%0b r=%0d e=%0b want v=1 r=3 e=1",
               valid, rng, err);
    end
    tick();
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_after_collide: got err=%0b want 1", err);
    end
  endtask

  task automatic test_glitch();
    int highs;
    do_reset(8'h01, 1'b0, 1'b1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      coded = (i % 2 == 0) ? 8'h01 : 8'h03;
      tick();
      if (valid) highs++;
      tick();
      if (valid) highs++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid) highs++;
    end
    n_vec++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL glitch_quiet: got %0d valid cycles want 0", highs);
    end
    tick();
    n_vec++;
    if ({valid, temp, rng} !== {1'b1, 5'd20, 2'b00}) begin
      n_bad++;
      $display("FAIL glitch_result: got v=%0b t=%0d r=%0d want v=1 t=20 r=0", valid, temp, rng);
    end
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_single: got valid=%0b want 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(8'h07, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) tick();
    coded = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({valid, temp, rng} !== {1'b1, 5'd21, 2'b00}) begin
        n_bad++;
        $display("FAIL b2b_pending[%0d]: got v=%0b t=%0d r=%0d want v=1 t=21 r=0",
                 i, valid, temp, rng);
      end
    end
    ready = 1'b1;
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap: got valid=%0b want 0", valid);
    end
    tick();
    n_vec++;
    if ({valid, temp, rng} !== {1'b1, 5'd22, 2'b00}) begin
      n_bad++;
      $display("FAIL b2b_next: got v=%0b t=%0d r=%0d want v=1 t=22 r=0", valid, temp, rng);
    end
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drop: got valid=%0b want 0", valid);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset(8'h01, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) tick();
    n_vec++;
    if ({valid2, temp2, rng2, cnt2} !== {1'b1, 5'd18, 2'b01, 2'd1}) begin
      n_bad++;
      $display("FAIL sat_first: got v=%0b t=%0d r=%0d c=%0d want v=1 t=18 r=1 c=1",
               valid2, temp2, rng2, cnt2);
    end
    for (int k = 2; k <= 5; k++) begin
      coded = 8'h07; alert = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      n_vec++;
      if ({valid2, rng2} !== {1'b1, 2'b00}) begin
        n_bad++;
        $display("FAIL sat_normal[%0d]: got v=%0b r=%0d want v=1 r=0", k, valid2, rng2);
      end
      coded = 8'h01; alert = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      n_vec++;
      if ({valid2, rng2, cnt2} !== {1'b1, 2'b01, exp_cnt}) begin
        n_bad++;
        $display("FAIL sat_under[%0d]: got v=%0b r=%0d c=%0d want v=1 r=1 c=%0d",
                 k, valid2, rng2, cnt2, exp_cnt);
      end
    end
    n_vec++;
    if (cnt !== 8'd5) begin
      n_bad++;
      $display("FAIL sat_wide_cnt: got %0d want 5", cnt);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if ({cnt2, cnt} !== '0) begin
      n_bad++;
      $display("FAIL sat_clr: got c2=%0d c=%0d want 0 0", cnt2, cnt);
    end
  endtask

  task automatic test_reset_in_pend();
    int highs;
    do_reset(8'hFF, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) tick();
    n_vec++;
    if ({valid, cnt} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL rip_pending: got v=%0b c=%0d want v=1 c=1", valid, cnt);
    end
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({valid, temp, rng, cnt} !== '0) begin
      n_bad++;
      $display("FAIL rip_async: got v=%0b t=%0d r=%0d c=%0d want all 0", valid, temp, rng, cnt);
    end
    tick();
    rst_n = 1'b1;
    highs = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (valid) highs++;
    end
    n_vec++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL rip_early: got %0d valid cycles want 0", highs);
    end
    tick();
    n_vec++;
    if ({valid, temp, rng, cnt} !== {1'b1, 5'd27, 2'b10, 8'd1}) begin
      n_bad++;
      $display("FAIL rip_rereport: got v=%0b t=%0d r=%0d c=%0d want v=1 t=27 r=2 c=1",
               valid, temp, rng, cnt);
    end
    ready = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; coded = '0; alert = 1'b0; ready = 1'b0; clr = 1'b0;
    ref_alert = 1'b0; ref_coded = '0;
    test_code_check();
    test_reset();
    test_normal_pulse();
    test_over_hold();
    test_invalid_err();
    test_glitch();
    test_back_to_back();
    test_saturation();
    test_reset_in_pend();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
